// File: rtl/fb_write_arbiter.sv
// Two-requester framebuffer write arbiter with full-screen clear sweep.
// Optional TEAR_FREE_EN: grants and clear writes issue only during vblank.
module fb_write_arbiter #(
  parameter int CELLS      = 4800,
  parameter int AW         = 13,
  parameter int CW         = 3,
  parameter int CLEAR_CODE = 0
) (
  input  logic          dclk,
  input  logic          clr_n,
  input  logic          vblank,
  input  logic          req0,
  input  logic [AW-1:0] addr0,
  input  logic [CW-1:0] data0,
  output logic          gnt0,
  input  logic          req1,
  input  logic [AW-1:0] addr1,
  input  logic [CW-1:0] data1,
  output logic          gnt1,
  input  logic          clear_req,
  output logic          clear_done,
  output logic          busy,
  output logic          fb_we,
  output logic [AW-1:0] fb_addr,
  output logic [CW-1:0] fb_data,
  output logic          frame_tick,
  output logic          err_addr
);

  typedef enum logic {IDLE, CLEAR} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          last_q, last_d;
  logic          gnt0_q, gnt0_d;
  logic          gnt1_q, gnt1_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [CW-1:0] data_q, data_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          vb_q;
  logic          tick_q;

  logic          go;
  logic          e0, e1;
  logic          pick1;
  logic [AW-1:0] sel_addr;
  logic          oor;

`ifdef TEAR_FREE_EN
  assign go = vblank;
`else
  assign go = 1'b1;
`endif

  // a requester granted last cycle still shows its old request
  assign e0 = req0 & ~gnt0_q;
  assign e1 = req1 & ~gnt1_q;
  assign pick1 = e1 & (~e0 | ~last_q);
  assign sel_addr = pick1 ? addr1 : addr0;
  assign oor = sel_addr >= AW'(CELLS);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    gnt0_d  = 1'b0;
    gnt1_d  = 1'b0;
    we_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (clear_req) begin
          state_d = CLEAR;
          cnt_d   = '0;
          err_d   = 1'b0;
        end else if (go && (e0 || e1)) begin
          gnt0_d = ~pick1;
          gnt1_d = pick1;
          last_d = pick1;
          we_d   = ~oor;
          addr_d = sel_addr;
          data_d = pick1 ? data1 : data0;
          err_d  = err_q | oor;
        end
      end
      CLEAR: begin
        busy_d = 1'b1;
        if (go) begin
          we_d   = 1'b1;
          addr_d = cnt_q;
          data_d = CW'(CLEAR_CODE);
          if (cnt_q == AW'(CELLS - 1)) begin
            done_d  = 1'b1;
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge dclk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b1;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      vb_q    <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      vb_q    <= vblank;
      tick_q  <= vblank & ~vb_q;
    end
  end

  assign gnt0       = gnt0_q;
  assign gnt1       = gnt1_q;
  assign fb_we      = we_q;
  assign fb_addr    = addr_q;
  assign fb_data    = data_q;
  assign busy       = busy_q;
  assign clear_done = done_q;
  assign err_addr   = err_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Directed bench for fb_write_arbiter.
// Build with TEAR_FREE_EN to add the vblank-gated sweep scenario.
module tb_fb_write_arbiter;

  localparam int AW = 13;
  localparam int CW = 3;

  logic          dclk = 1'b0;
  logic          clr_n;
  logic          vblank;
  logic          req0, req1, clear_req;
  logic [AW-1:0] addr0, addr1;
  logic [CW-1:0] data0, data1;
  logic          gnt0, gnt1, clear_done, busy;
  logic          fb_we, frame_tick, err_addr;
  logic [AW-1:0] fb_addr;
  logic [CW-1:0] fb_data;

  int checks = 0;
  int failures = 0;

  always #20 dclk = ~dclk;

  fb_write_arbiter dut (
    .dclk(dclk), .clr_n(clr_n), .vblank(vblank),
    .req0(req0), .addr0(addr0), .data0(data0), .gnt0(gnt0),
    .req1(req1), .addr1(addr1), .data1(data1), .gnt1(gnt1),
    .clear_req(clear_req), .clear_done(clear_done), .busy(busy),
    .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data),
    .frame_tick(frame_tick), .err_addr(err_addr)
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    clr_n = 1'b0;
    repeat (2) @(negedge dclk);
    clr_n = 1'b1;
  endtask

  initial begin
    int n, bad, gseen, done_at, wes;
    bool_init: begin
      clr_n = 1'b0; vblank = 1'b1;
      req0 = 1'b0; req1 = 1'b0; clear_req = 1'b0;
      addr0 = '0; addr1 = '0; data0 = '0; data1 = '0;
    end
    do_reset();
    #1;
    check("rst_ctl", {gnt0, gnt1, fb_we, busy, clear_done, err_addr}, 0);
    check("rst_addr", fb_addr, 0);
    check("rst_data", fb_data, 0);

    // single request
    @(negedge dclk);
    req0 = 1'b1; addr0 = 13'd5; data0 = 3'd3;
    @(negedge dclk);
    check("t1_gnt", {gnt0, gnt1}, 2);
    check("t1_we", fb_we, 1);
    check("t1_addr", fb_addr, 5);
    check("t1_data", fb_data, 3);
    check("t1_err", err_addr, 0);
    req0 = 1'b0;
    @(negedge dclk);
    check("t1_idle", {gnt0, fb_we}, 0);

    // contention round-robin, requester 0 first after reset
    do_reset();
    req0 = 1'b1; addr0 = 13'd10; data0 = 3'd1;
    req1 = 1'b1; addr1 = 13'd20; data1 = 3'd2;
    for (int i = 0; i < 6; i++) begin
      @(negedge dclk);
      check("t2_gnt", {gnt0, gnt1}, (i % 2 == 0) ? 2 : 1);
      check("t2_we", fb_we, 1);
      check("t2_addr", fb_addr, (i % 2 == 0) ? 10 : 20);
    end
    req0 = 1'b0; req1 = 1'b0;
    @(negedge dclk);

    // out-of-range address
    req1 = 1'b1; addr1 = 13'd4800; data1 = 3'd5;
    @(negedge dclk);
    check("t3_gnt1", gnt1, 1);
    check("t3_we", fb_we, 0);
    check("t3_err", err_addr, 1);
    req1 = 1'b0;
    repeat (3) @(negedge dclk);
    check("t3_sticky", err_addr, 1);

    // clear sweep with a pending request
    clear_req = 1'b1; req0 = 1'b1; addr0 = 13'd7; data0 = 3'd6;
    @(negedge dclk);
    clear_req = 1'b0;
    check("t4_errclr", err_addr, 0);
    n = 0; bad = 0; gseen = 0; done_at = -1;
    for (int k = 0; k < 6000 && done_at < 0; k++) begin
      @(negedge dclk);
      if (gnt0 || gnt1) gseen++;
      if (fb_we) begin
        if (fb_addr != n[AW-1:0] || fb_data != 0 || !busy) bad++;
        n++;
      end
      if (clear_done) done_at = int'(fb_addr);
    end
    check("t4_writes", n, 4800);
    check("t4_order", bad, 0);
    check("t4_nognt", gseen, 0);
    check("t4_done", done_at, 4799);
    @(negedge dclk);
    check("t4_gnt0", gnt0, 1);
    check("t4_addr", fb_addr, 7);
    check("t4_busy", busy, 0);
    req0 = 1'b0;
    @(negedge dclk);

`ifdef TEAR_FREE_EN
    vblank = 1'b0; clear_req = 1'b1;
    @(negedge dclk);
    clear_req = 1'b0;
    wes = 0;
    repeat (10) begin
      @(negedge dclk);
      if (fb_we) wes++;
    end
    check("t5_hold", wes, 0);
    vblank = 1'b1;
    n = 0; bad = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge dclk);
      if (fb_we) begin
        if (fb_addr != n[AW-1:0]) bad++;
        n++;
      end
    end
    vblank = 1'b0;
    check("t5_writes", n, 100);
    check("t5_order", bad, 0);
    wes = 0;
    repeat (5) begin
      @(negedge dclk);
      if (fb_we) wes++;
    end
    check("t5_gap", wes, 0);
    vblank = 1'b1;
    @(negedge dclk);
    check("t5_resume", {fb_we, fb_addr}, {1'b1, 13'd100});
    do_reset();
`endif

    // reset mid-sweep, then frame_tick
    vblank = 1'b1; clear_req = 1'b1;
    @(negedge dclk);
    clear_req = 1'b0;
    done_at = -1;
    for (int k = 0; k < 3000 && done_at < 0; k++) begin
      @(negedge dclk);
      if (fb_we && fb_addr == 13'd2000) done_at = 2000;
    end
    check("t6_reach", done_at, 2000);
    #1 clr_n = 1'b0;
    #1;
    check("t6_ctl", {fb_we, busy, clear_done, gnt0, gnt1}, 0);
    check("t6_addr", fb_addr, 0);
    vblank = 1'b0;
    @(negedge dclk);
    clr_n = 1'b1;
    repeat (2) @(negedge dclk);
    check("t6_idle", {fb_we, busy, frame_tick}, 0);
    vblank = 1'b1;
    @(negedge dclk);
    check("t6_tick", frame_tick, 1);
    @(negedge dclk);
    check("t6_tick_off", frame_tick, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
